// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers active-area column/row, active qualifier,
// frame-start strobe and lock status from an active-low VGA sync stream.
// Ports: i_Clk, i_Reset (async, active high); i_HSync/i_VSync and RGB in;
// o_Active, o_Col_Count, o_Row_Count, o_Frame_Start, gated RGB, o_Locked.
// Every output is 3 clocks behind the input pins.
module vga_sync_decoder #(
  parameter int VIDEO_WIDTH      = 3,
  parameter int TOTAL_COLS       = 800,
  parameter int TOTAL_ROWS       = 525,
  parameter int ACTIVE_COLS      = 640,
  parameter int ACTIVE_ROWS      = 480,
  parameter int FRONT_PORCH_HORZ = 18,
  parameter int FRONT_PORCH_VERT = 10,
  parameter int LOCK_LINES       = 4
) (
  input  logic                           i_Clk,
  input  logic                           i_Reset,
  input  logic                           i_HSync,
  input  logic                           i_VSync,
  input  logic [VIDEO_WIDTH-1:0]         i_Red_Video,
  input  logic [VIDEO_WIDTH-1:0]         i_Grn_Video,
  input  logic [VIDEO_WIDTH-1:0]         i_Blu_Video,
  output logic                           o_Active,
  output logic [$clog2(ACTIVE_COLS)-1:0] o_Col_Count,
  output logic [$clog2(ACTIVE_ROWS)-1:0] o_Row_Count,
  output logic                           o_Frame_Start,
  output logic [VIDEO_WIDTH-1:0]         o_Red_Video,
  output logic [VIDEO_WIDTH-1:0]         o_Grn_Video,
  output logic [VIDEO_WIDTH-1:0]         o_Blu_Video,
  output logic                           o_Locked
);

  localparam int HW = $clog2(2*TOTAL_COLS);
  localparam int VW = $clog2(2*TOTAL_ROWS);
  localparam int CW = $clog2(ACTIVE_COLS);
  localparam int RW = $clog2(ACTIVE_ROWS);
  localparam int GW = $clog2(LOCK_LINES+1);

  localparam int H_START =
    TOTAL_COLS - FRONT_PORCH_HORZ - ACTIVE_COLS;
  localparam int V_START =
    TOTAL_ROWS - FRONT_PORCH_VERT - ACTIVE_ROWS - 1;

  localparam logic [HW-1:0] H_MAX  = HW'(2*TOTAL_COLS-1);
  localparam logic [HW-1:0] H_TO   = HW'(2*TOTAL_COLS-2);
  localparam logic [HW-1:0] H_LINE = HW'(TOTAL_COLS-1);
  localparam logic [HW-1:0] H_LO   = HW'(H_START);
  localparam logic [HW-1:0] H_HI   = HW'(H_START+ACTIVE_COLS);

  localparam logic [VW-1:0] V_MAX   = VW'(2*TOTAL_ROWS-1);
  localparam logic [VW-1:0] V_FRAME = VW'(TOTAL_ROWS-1);
  localparam logic [VW-1:0] V_LO    = VW'(V_START);
  localparam logic [VW-1:0] V_HI    = VW'(V_START+ACTIVE_ROWS);

  localparam logic [GW-1:0] G_LAST = GW'(LOCK_LINES-1);

  typedef enum logic [1:0] {
    UNLOCKED,
    H_LOCKED,
    V_ALIGN,
    LOCKED
  } state_t;

  state_t state;
  state_t state_nxt;

  logic hs1;
  logic hs2;
  logic vs1;
  logic vs2;
  logic [VIDEO_WIDTH-1:0] r1;
  logic [VIDEO_WIDTH-1:0] g1;
  logic [VIDEO_WIDTH-1:0] b1;
  logic [VIDEO_WIDTH-1:0] r2;
  logic [VIDEO_WIDTH-1:0] g2;
  logic [VIDEO_WIDTH-1:0] b2;

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          v_pend;
  logic          phase_ok;
  logic [GW-1:0] good_lines;
  logic [GW-1:0] good_nxt;

  logic hs_fall;
  logic vs_fall;
  logic reload;
  logic timeout;
  logic line_good;
  logic line_bad;
  logic frame_good;

  logic          win;
  logic [CW-1:0] col_v;
  logic [RW-1:0] row_v;

  // two-stage input register; syncs idle high
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      hs1 <= 1'b1;
      hs2 <= 1'b1;
      vs1 <= 1'b1;
      vs2 <= 1'b1;
      r1  <= '0;
      g1  <= '0;
      b1  <= '0;
      r2  <= '0;
      g2  <= '0;
      b2  <= '0;
    end else begin
      hs1 <= i_HSync;
      hs2 <= hs1;
      vs1 <= i_VSync;
      vs2 <= vs1;
      r1  <= i_Red_Video;
      g1  <= i_Grn_Video;
      b1  <= i_Blu_Video;
      r2  <= r1;
      g2  <= g1;
      b2  <= b1;
    end
  end

  assign hs_fall = hs2 & ~hs1;
  assign vs_fall = vs2 & ~vs1;

  // a VSync fall in the same cycle as the HSync fall counts as pending
  assign reload = hs_fall & (v_pend | vs_fall);

  // h_cnt saturates, so the timeout fires once on the step to H_MAX
  assign timeout = ~hs_fall & (h_cnt == H_TO);

  assign line_good = hs_fall & phase_ok & (h_cnt == H_LINE);
  assign line_bad  = (hs_fall & phase_ok & (h_cnt != H_LINE))
                   | timeout;

  assign frame_good = (v_cnt == V_FRAME);

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      h_cnt    <= '0;
      v_cnt    <= '0;
      v_pend   <= 1'b0;
      phase_ok <= 1'b0;
    end else begin
      if (hs_fall) begin
        h_cnt <= '0;
      end else if (h_cnt != H_MAX) begin
        h_cnt <= h_cnt + 1'b1;
      end

      if (reload) begin
        v_cnt <= '0;
      end else if (hs_fall && (v_cnt != V_MAX)) begin
        v_cnt <= v_cnt + 1'b1;
      end

      if (reload) begin
        v_pend <= 1'b0;
      end else if (vs_fall) begin
        v_pend <= 1'b1;
      end

      // first edge after reset only establishes line phase
      if (hs_fall) begin
        phase_ok <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state      <= UNLOCKED;
      good_lines <= '0;
    end else begin
      state      <= state_nxt;
      good_lines <= good_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    good_nxt  = good_lines;
    if (line_bad) begin
      state_nxt = UNLOCKED;
      good_nxt  = '0;
    end else begin
      unique case (state)
        UNLOCKED: begin
          if (line_good) begin
            if (good_lines == G_LAST) begin
              state_nxt = H_LOCKED;
              good_nxt  = '0;
            end else begin
              good_nxt = good_lines + 1'b1;
            end
          end
        end
        H_LOCKED: begin
          if (reload) begin
            state_nxt = V_ALIGN;
          end
        end
        V_ALIGN: begin
          if (reload && frame_good) begin
            state_nxt = LOCKED;
          end
        end
        LOCKED: begin
          if (reload && !frame_good) begin
            state_nxt = V_ALIGN;
          end
        end
        default: begin
          state_nxt = UNLOCKED;
          good_nxt  = '0;
        end
      endcase
    end
  end

  // window test runs on stage-2 data, aligned with h_cnt/v_cnt
  always_comb begin
    win = (state == LOCKED)
        && (h_cnt >= H_LO) && (h_cnt < H_HI)
        && (v_cnt >= V_LO) && (v_cnt < V_HI);
    col_v = '0;
    row_v = '0;
    if (win) begin
      col_v = CW'(h_cnt - H_LO);
      row_v = RW'(v_cnt - V_LO);
    end
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      o_Active      <= 1'b0;
      o_Col_Count   <= '0;
      o_Row_Count   <= '0;
      o_Frame_Start <= 1'b0;
      o_Red_Video   <= '0;
      o_Grn_Video   <= '0;
      o_Blu_Video   <= '0;
      o_Locked      <= 1'b0;
    end else begin
      o_Active      <= win;
      o_Col_Count   <= col_v;
      o_Row_Count   <= row_v;
      o_Frame_Start <= win && (col_v == '0)
                           && (row_v == '0);
      o_Red_Video   <= win ? r2 : '0;
      o_Grn_Video   <= win ? g2 : '0;
      o_Blu_Video   <= win ? b2 : '0;
      o_Locked      <= (state == LOCKED);
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: drives a scaled porch-generator stream
// (40x30 total, 16x12 active) and checks the decoder outputs.
module tb_vga_sync_decoder;

  localparam int TC    = 40;
  localparam int TR    = 30;
  localparam int AC    = 16;
  localparam int AR    = 12;
  localparam int FPH   = 4;
  localparam int FPV   = 3;
  localparam int LL    = 4;
  localparam int HS_LO = AC + FPH;
  localparam int HS_N  = 8;
  localparam int VS_LO = AR + FPV;
  localparam int NPIX  = AC * AR;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hs  = 1'b1;
  logic vs  = 1'b1;
  logic [2:0] ri = '0;
  logic [2:0] gi = '0;
  logic [2:0] bi = '0;
  logic [2:0] ro;
  logic [2:0] go;
  logic [2:0] bo;
  logic act;
  logic fs;
  logic lk;
  logic [3:0] col;
  logic [3:0] row;

  int n_chk = 0;
  int n_bad = 0;
  int act_seen = 0;
  int fs_seen = 0;
  logic exp_lock = 1'b0;
  logic in_rst = 1'b1;

  typedef struct packed {
    logic        chk;
    logic [18:0] val;
  } exp_t;

  exp_t pipe [3];

  always #5 clk = ~clk;

  vga_sync_decoder #(
    .VIDEO_WIDTH(3),
    .TOTAL_COLS(TC),
    .TOTAL_ROWS(TR),
    .ACTIVE_COLS(AC),
    .ACTIVE_ROWS(AR),
    .FRONT_PORCH_HORZ(FPH),
    .FRONT_PORCH_VERT(FPV),
    .LOCK_LINES(LL)
  ) dut (
    .i_Clk(clk),
    .i_Reset(rst),
    .i_HSync(hs),
    .i_VSync(vs),
    .i_Red_Video(ri),
    .i_Grn_Video(gi),
    .i_Blu_Video(bi),
    .o_Active(act),
    .o_Col_Count(col),
    .o_Row_Count(row),
    .o_Frame_Start(fs),
    .o_Red_Video(ro),
    .o_Grn_Video(go),
    .o_Blu_Video(bo),
    .o_Locked(lk)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h t=%0t",
               tag, got, want, $time);
    end
  endtask

  // one pixel per negedge; outputs seen now belong to the
  // pixel driven three negedges earlier
  task automatic send_px(input int r, input int c);
    logic        reg_in;
    logic        a;
    logic [2:0]  px;
    logic [18:0] v;
    @(negedge clk);
    if (pipe[2].chk)
      check("pix", {13'd0, act, fs, col, row, ro, go, bo},
            {13'd0, pipe[2].val});
    if (act) act_seen++;
    if (fs) fs_seen++;
    reg_in = (r >= 0) && (r < AR) && (c >= 0) && (c < AC);
    a  = exp_lock && reg_in;
    px = reg_in ? 3'(c % 8) : 3'd0;
    v  = a ? {1'b1, (r == 0 && c == 0), 4'(c), 4'(r),
              px, px, px} : 19'd0;
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0].chk = !in_rst;
    pipe[0].val = v;
    hs = !((c >= HS_LO) && (c < HS_LO + HS_N));
    vs = !((r == VS_LO) || (r == VS_LO + 1));
    ri = px;
    gi = px;
    bi = px;
  endtask

  task automatic send_line(input int r, input int c0, input int c1);
    for (int c = c0; c < c1; c++) send_px(r, c);
  endtask

  task automatic send_rows(input int r0, input int r1);
    for (int r = r0; r < r1; r++) send_line(r, 0, TC);
  endtask

  task automatic run_frame(input string t, input int na, input int nf);
    act_seen = 0;
    fs_seen  = 0;
    send_rows(0, TR);
    check({t, "_act"}, act_seen, na);
    check({t, "_fs"}, fs_seen, nf);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) pipe[i] = '0;
    repeat (2) @(negedge clk);
    check("rst_out", {lk, act, fs, col, row, ro, go, bo}, 0);
    rst    = 1'b0;
    in_rst = 1'b0;

    // acquire: phase, 4 good lines, then two VSync reloads
    run_frame("f1", 0, 0);
    check("lk_f1", lk, 0);
    run_frame("f2", 0, 0);
    check("lk_f2", lk, 1);
    exp_lock = 1'b1;

    // first locked frame with explicit corner coordinates
    act_seen = 0;
    fs_seen  = 0;
    send_line(0, 0, 4);
    check("c00", {act, fs, col, row}, 10'b11_0000_0000);
    send_line(0, 4, TC);
    send_rows(1, AR - 1);
    send_line(AR - 1, 0, AC + 3);
    check("c_last", {act, col, row}, {1'b1, 4'd15, 4'd11});
    send_px(AR - 1, AC + 3);
    check("c_after", {act, ro, go, bo}, 0);
    send_line(AR - 1, AC + 4, TC);
    send_rows(AR, TR);
    check("f3_act", act_seen, NPIX);
    check("f3_fs", fs_seen, 1);

    run_frame("f4", NPIX, 1);

    // 39-clock line in the front porch; detected at next HSync
    act_seen = 0;
    fs_seen  = 0;
    send_rows(0, 13);
    send_line(13, 0, TC - 1);
    send_line(14, 0, HS_LO + 3);
    check("lk_hold", lk, 1);
    send_px(14, HS_LO + 3);
    check("lk_drop", lk, 0);
    exp_lock = 1'b0;
    send_line(14, HS_LO + 4, TC);
    send_rows(15, TR);
    check("f5_act", act_seen, NPIX);
    check("f5_fs", fs_seen, 1);
    run_frame("f6", 0, 0);
    run_frame("f7", 0, 0);
    check("lk_f7", lk, 1);
    exp_lock = 1'b1;
    run_frame("f8", NPIX, 1);

    // 29-line frame: bad frame at the next reload
    act_seen = 0;
    fs_seen  = 0;
    send_rows(0, AR);
    send_rows(AR + 1, VS_LO + 1);
    exp_lock = 1'b0;
    send_rows(VS_LO + 1, TR);
    check("lk_f9", lk, 0);
    check("f9_act", act_seen, NPIX);
    run_frame("f10", 0, 0);
    check("lk_f10", lk, 1);
    exp_lock = 1'b1;
    run_frame("f11", NPIX, 1);

    // HSync stuck high: timeout unlocks, h_cnt saturates
    act_seen = 0;
    send_rows(0, VS_LO + 1);
    check("lk_pre_to", lk, 1);
    check("f12_act", act_seen, NPIX);
    exp_lock = 1'b0;
    repeat (100) send_px(-1, -1);
    check("lk_to", lk, 0);
    check("hsat", 32'(dut.h_cnt), 2 * TC - 1);
    run_frame("f13", 0, 0);
    run_frame("f14", 0, 0);
    check("lk_f14", lk, 1);
    exp_lock = 1'b1;
    run_frame("f15", NPIX, 1);

    // asynchronous reset in the middle of an active line
    send_rows(0, 5);
    send_line(5, 0, 9);
    #2;
    check("pre_rst", {act, col, row}, {1'b1, 4'd5, 4'd5});
    rst    = 1'b1;
    in_rst = 1'b1;
    for (int i = 0; i < 3; i++) pipe[i].chk = 1'b0;
    #1;
    check("rst_async", {lk, act, fs, col, row, ro, go, bo}, 0);
    exp_lock = 1'b0;
    send_line(5, 9, TC);
    send_rows(6, 7);
    send_line(7, 0, 10);
    rst    = 1'b0;
    in_rst = 1'b0;
    act_seen = 0;
    send_line(7, 10, TC);
    send_rows(8, TR);
    check("f16_act", act_seen, 0);
    check("lk_f16", lk, 0);
    run_frame("f17", 0, 0);
    check("lk_f17", lk, 1);
    exp_lock = 1'b1;
    run_frame("f18", NPIX, 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
